// File: rtl/be8_control_unit_if.sv
// be8_control_unit_if
// Groups the run/step controls, the datapath status inputs and the control
// word outputs of the be8 microcode sequencer.
//   RUN, STEP         : free-run level and single-step request
//   OPCODE, CF, ZF    : instruction register high nibble and ALU flags
//   CTRL              : 19-bit control word to the datapath
//   HALTED, STEP_CNT  : halt indication and current micro-step (debug)
// Modports: slave is the sequencer itself, master is whoever drives it.
interface be8_control_unit_if;
    logic        RUN;
    logic        STEP;
    logic [3:0]  OPCODE;
    logic        CF;
    logic        ZF;
    logic [18:0] CTRL;
    logic        HALTED;
    logic [2:0]  STEP_CNT;

    modport slave (
        input  RUN, STEP, OPCODE, CF, ZF,
        output CTRL, HALTED, STEP_CNT
    );

    modport master (
        output RUN, STEP, OPCODE, CF, ZF,
        input  CTRL, HALTED, STEP_CNT
    );
endinterface

// File: rtl/be8_control_unit.sv
// be8_control_unit
// Microcode sequencer for the be8 8-bit CPU. Produces one micro-step of the
// datapath control word per enabled clock, with reset clear, halt and
// run/single-step gating.
// Ports:
//   CLK     : system clock, rising edge
//   RESETn  : asynchronous active-low reset
//   bus     : be8_control_unit_if.slave (RUN, STEP, OPCODE, CF, ZF in;
//             CTRL, HALTED, STEP_CNT out)
// Parameters:
//   EARLY_END : 1 = return to T0 after the instruction's last active step
//   STEP_SYNC : 1 = STEP passes a 2-flop synchronizer before edge detect
// CTRL bit order [18:0]: CLR CE SU AIn BIn OIn IIn Jn FIn MIn RI DOn AOn BOn
// IOn COn EOn ROn NOn (the *n bits are active-low).
module be8_control_unit #(
    parameter bit EARLY_END = 1'b1,
    parameter bit STEP_SYNC = 1'b1
) (
    input logic              CLK,
    input logic              RESETn,
    be8_control_unit_if.slave bus
);

    localparam int unsigned B_CLR = 18;
    localparam int unsigned B_CE  = 17;
    localparam int unsigned B_SU  = 16;
    localparam int unsigned B_AI  = 15;
    localparam int unsigned B_BI  = 14;
    localparam int unsigned B_OI  = 13;
    localparam int unsigned B_II  = 12;
    localparam int unsigned B_JN  = 11;
    localparam int unsigned B_FI  = 10;
    localparam int unsigned B_MI  = 9;
    localparam int unsigned B_RI  = 8;
    localparam int unsigned B_AON = 6;
    localparam int unsigned B_BON = 5;
    localparam int unsigned B_ION = 4;
    localparam int unsigned B_CON = 3;
    localparam int unsigned B_EON = 2;
    localparam int unsigned B_RON = 1;

    localparam logic [18:0] IDLE_WORD = 19'h008FF;
    localparam logic [18:0] CLR_WORD  = 19'h408FF;

    localparam logic [1:0] S_CLR  = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state;
    logic [2:0]  step_cnt;
    logic        halted;
    logic        step_in;
    logic        step_prev;
    logic        step_rise;
    logic        adv;
    logic [18:0] dec_word;
    logic [2:0]  op_last;
    logic        hlt_step;
    logic [18:0] ctrl_word;

    // Optional two-flop synchronizer for an asynchronous STEP button.
    generate
        if (STEP_SYNC) begin : g_sync
            logic step_s1;
            logic step_s2;
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    step_s1 <= 1'b0;
                    step_s2 <= 1'b0;
                end else begin
                    step_s1 <= bus.STEP;
                    step_s2 <= step_s1;
                end
            end
            assign step_in = step_s2;
        end else begin : g_nosync
            assign step_in = bus.STEP;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_in;
        end
    end

    // A held STEP yields a single pulse; RUN and a step pulse together
    // still mean just one advance.
    assign step_rise = step_in & ~step_prev;
    assign adv       = bus.RUN | step_rise;

    // Last active micro-step of each opcode, used for early return to T0.
    always_comb begin
        op_last = 3'd1;
        case (bus.OPCODE)
            4'd1, 4'd4:                          op_last = 3'd3;
            4'd2, 4'd3:                          op_last = 3'd4;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd14, 4'd15: op_last = 3'd2;
            default:                             op_last = 3'd1;
        endcase
    end

    // Micro-step decode. T0/T1 are the common fetch and ignore OPCODE;
    // the flags only matter in T2, where the conditional jumps live.
    always_comb begin
        dec_word = IDLE_WORD;
        hlt_step = 1'b0;
        case (step_cnt)
            3'd0: begin
                dec_word[B_CON] = 1'b0;
                dec_word[B_MI]  = 1'b1;
            end
            3'd1: begin
                dec_word[B_RON] = 1'b0;
                dec_word[B_II]  = 1'b1;
                dec_word[B_CE]  = 1'b1;
            end
            3'd2: begin
                case (bus.OPCODE)
                    4'd1, 4'd2, 4'd3, 4'd4: begin
                        dec_word[B_ION] = 1'b0;
                        dec_word[B_MI]  = 1'b1;
                    end
                    4'd5: begin
                        dec_word[B_ION] = 1'b0;
                        dec_word[B_AI]  = 1'b1;
                    end
                    4'd6: begin
                        dec_word[B_ION] = 1'b0;
                        dec_word[B_JN]  = 1'b0;
                    end
                    4'd7: begin
                        if (bus.CF) begin
                            dec_word[B_ION] = 1'b0;
                            dec_word[B_JN]  = 1'b0;
                        end
                    end
                    4'd8: begin
                        if (bus.ZF) begin
                            dec_word[B_ION] = 1'b0;
                            dec_word[B_JN]  = 1'b0;
                        end
                    end
                    4'd14: begin
                        dec_word[B_AON] = 1'b0;
                        dec_word[B_OI]  = 1'b1;
                    end
                    4'd15: hlt_step = 1'b1;
                    default: ;
                endcase
            end
            3'd3: begin
                case (bus.OPCODE)
                    4'd1: begin
                        dec_word[B_RON] = 1'b0;
                        dec_word[B_AI]  = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        dec_word[B_RON] = 1'b0;
                        dec_word[B_BI]  = 1'b1;
                    end
                    4'd4: begin
                        dec_word[B_AON] = 1'b0;
                        dec_word[B_RI]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                if (bus.OPCODE == 4'd2 || bus.OPCODE == 4'd3) begin
                    dec_word[B_EON] = 1'b0;
                    dec_word[B_AI]  = 1'b1;
                    dec_word[B_FI]  = 1'b1;
                    dec_word[B_SU]  = (bus.OPCODE == 4'd3);
                end
            end
            default: ;
        endcase
    end

    // Sequencer state. The HLT edge moves straight to S_HALT and leaves
    // STEP_CNT where it was, so the debug display shows the halting step.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= S_CLR;
            step_cnt <= 3'd0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_CLR: begin
                    state    <= S_RUN;
                    step_cnt <= 3'd0;
                end
                S_RUN: begin
                    if (adv) begin
                        if (hlt_step) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else if ((EARLY_END && step_cnt == op_last) ||
                                     step_cnt == 3'd4) begin
                            step_cnt <= 3'd0;
                        end else begin
                            step_cnt <= step_cnt + 3'd1;
                        end
                    end
                end
                S_HALT: ;
                default: state <= S_CLR;
            endcase
        end
    end

    // Output gating; reset is checked directly so the clear word never
    // appears while RESETn is still low.
    always_comb begin
        ctrl_word = IDLE_WORD;
        if (RESETn) begin
            case (state)
                S_CLR:   ctrl_word = CLR_WORD;
                S_RUN:   ctrl_word = adv ? dec_word : IDLE_WORD;
                default: ctrl_word = IDLE_WORD;
            endcase
        end
    end

    assign bus.CTRL     = ctrl_word;
    assign bus.HALTED   = halted;
    assign bus.STEP_CNT = step_cnt;

endmodule
